// File: rtl/tlc_safety_monitor.sv
// Lamp conflict/sequence/dwell monitor; on any violation latches a fault code and flashes red on both directions.
// Latency 2 cycles (input register + output register); no backpressure, every cycle is checked.
module tlc_safety_monitor #(
  parameter int MIN_GRN   = 4,
  parameter int MIN_YLW   = 2,
  parameter int MAX_DWELL = 200,
  parameter int CNT_W     = 8,
  parameter int FLASH_DIV = 16
) (
  input  logic       CK,
  input  logic       CLR,
  input  logic       GRN1,
  input  logic       YLW1,
  input  logic       RED1,
  input  logic       GRN2,
  input  logic       YLW2,
  input  logic       RED2,
  input  logic       FACK,
  output logic       LG1,
  output logic       LY1,
  output logic       LR1,
  output logic       LG2,
  output logic       LY2,
  output logic       LR2,
  output logic       FAULT,
  output logic [2:0] FCODE
);

  localparam int FL_W = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
  localparam logic [CNT_W-1:0] MIN_GRN_C   = CNT_W'(MIN_GRN);
  localparam logic [CNT_W-1:0] MIN_YLW_C   = CNT_W'(MIN_YLW);
  localparam logic [CNT_W-1:0] MAX_DWELL_C = CNT_W'(MAX_DWELL);
  localparam logic [FL_W-1:0]  FLASH_LAST  = FL_W'(FLASH_DIV - 1);

  typedef enum logic [1:0] {ST_UNK, ST_G, ST_Y, ST_R} lamp_t;
  typedef enum logic {MONITOR, FAULTED} mode_t;

  logic [2:0]       s1_1, s1_2;
  lamp_t            trk1, trk2;
  logic [CNT_W-1:0] dwell1, dwell2;
  mode_t            mode;
  logic [FL_W-1:0]  flash_cnt;
  logic             flash;

  lamp_t      cur1, cur2;
  logic [3:0] seq1, seq2;
  logic       illegal, conflict, clean, viol;
  logic [5:0] flags;
  logic [2:0] vcode;

  // Non-one-hot codes decode to ST_UNK, which doubles as the illegal marker.
  function automatic lamp_t decode(input logic [2:0] gyr);
    case (gyr)
      3'b100:  return ST_G;
      3'b010:  return ST_Y;
      3'b001:  return ST_R;
      default: return ST_UNK;
    endcase
  endfunction

  // Bits 0..3 flag codes 3..6 for one direction.
  function automatic logic [3:0] seq_check(input lamp_t st, input logic [CNT_W-1:0] d,
                                           input lamp_t c);
    logic [3:0] f;
    f = '0;
    if (st != ST_UNK && c != ST_UNK) begin
      if (c != st) begin
        f[0] = !((st == ST_G && c == ST_Y) || (st == ST_Y && c == ST_R) ||
                 (st == ST_R && c == ST_G));
        f[1] = (st == ST_G) && (d < MIN_GRN_C);
        f[2] = (st == ST_Y) && (d < MIN_YLW_C);
      end else begin
        f[3] = (st == ST_G || st == ST_Y) && (d == MAX_DWELL_C);
      end
    end
    return f;
  endfunction

  function automatic logic [CNT_W-1:0] dwell_next(input lamp_t st, input logic [CNT_W-1:0] d,
                                                  input lamp_t c);
    if (c == ST_UNK) return d;
    if (st == ST_UNK || c != st) return CNT_W'(1);
    return (d == '1) ? d : d + 1'b1;
  endfunction

  always_comb begin
    cur1     = decode(s1_1);
    cur2     = decode(s1_2);
    seq1     = seq_check(trk1, dwell1, cur1);
    seq2     = seq_check(trk2, dwell2, cur2);
    illegal  = (cur1 == ST_UNK) || (cur2 == ST_UNK);
    conflict = ((s1_1[2] | s1_1[1]) & ~s1_2[0]) | ((s1_2[2] | s1_2[1]) & ~s1_1[0]);
    clean    = ~illegal & ~conflict;
    flags    = {seq1 | seq2, conflict, illegal};
    viol     = |flags;
    vcode    = '0;
    // Scan from the highest code down so the lowest asserted code is left standing.
    for (int i = 5; i >= 0; i--) begin
      if (flags[i]) vcode = 3'(i + 1);
    end
  end

  always_ff @(posedge CK) begin
    if (CLR) begin
      s1_1            <= 3'b001;
      s1_2            <= 3'b001;
      {LG1, LY1, LR1} <= 3'b001;
      {LG2, LY2, LR2} <= 3'b001;
      FAULT           <= 1'b0;
      FCODE           <= 3'd0;
      trk1            <= ST_UNK;
      trk2            <= ST_UNK;
      dwell1          <= '0;
      dwell2          <= '0;
      mode            <= MONITOR;
      flash_cnt       <= '0;
      flash           <= 1'b1;
    end else begin
      s1_1 <= {GRN1, YLW1, RED1};
      s1_2 <= {GRN2, YLW2, RED2};
      case (mode)
        MONITOR: begin
          if (viol) begin
            mode            <= FAULTED;
            FAULT           <= 1'b1;
            FCODE           <= vcode;
            flash_cnt       <= '0;
            flash           <= 1'b1;
            {LG1, LY1, LR1} <= 3'b001;
            {LG2, LY2, LR2} <= 3'b001;
          end else begin
            {LG1, LY1, LR1} <= s1_1;
            {LG2, LY2, LR2} <= s1_2;
            trk1            <= (cur1 == ST_UNK) ? trk1 : cur1;
            trk2            <= (cur2 == ST_UNK) ? trk2 : cur2;
            dwell1          <= dwell_next(trk1, dwell1, cur1);
            dwell2          <= dwell_next(trk2, dwell2, cur2);
          end
        end
        FAULTED: begin
          if (FACK && clean) begin
            mode            <= MONITOR;
            FAULT           <= 1'b0;
            FCODE           <= 3'd0;
            trk1            <= ST_UNK;
            trk2            <= ST_UNK;
            dwell1          <= '0;
            dwell2          <= '0;
            flash_cnt       <= '0;
            flash           <= 1'b1;
            {LG1, LY1, LR1} <= s1_1;
            {LG2, LY2, LR2} <= s1_2;
          end else begin
            {LG1, LY1} <= 2'b00;
            {LG2, LY2} <= 2'b00;
            if (flash_cnt == FLASH_LAST) begin
              flash_cnt <= '0;
              flash     <= ~flash;
              LR1       <= ~flash;
              LR2       <= ~flash;
            end else begin
              flash_cnt <= flash_cnt + 1'b1;
              LR1       <= flash;
              LR2       <= flash;
            end
          end
        end
      endcase
    end
  end

endmodule
